inst_loader: RTL

- Boot-time program loader that sits directly upstream of the single-cycle CPU's instruction memory.
- Accepts a byte stream through a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into instruction memory through its write port.
- Holds the CPU in reset through its own active-low reset output until the whole image is loaded, then releases it so execution starts at BASE_ADDR.

---
 rtl/inst_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// Boot-time program loader: receives a length-prefixed byte stream and writes big-endian
// 32-bit words into instruction memory, holding the CPU in reset until the image is complete.
module inst_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 64
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        Start,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemData,
  output logic        CpuClrn,
  output logic        Busy,
  output logic        Err,
  output logic [15:0] WordCnt
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR
  } state_t;

  state_t      state;
  logic [15:0] n;
  logic [1:0]  idx;
  logic [23:0] word;

  logic        xfer;
  logic [15:0] len_next;
  logic [15:0] cnt_next;

  always_comb begin
    xfer     = RxValid && RxReady;
    len_next = {n[15:8], RxData};
    cnt_next = WordCnt + 16'd1;
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state   <= IDLE;
      RxReady <= 1'b0;
      MemWe   <= 1'b0;
      MemAddr <= BASE_ADDR;
      MemData <= '0;
      CpuClrn <= 1'b0;
      Busy    <= 1'b0;
      Err     <= 1'b0;
      WordCnt <= '0;
      n       <= '0;
      idx     <= '0;
      word    <= '0;
    end else begin
      case (state)
        IDLE, ERR: begin
          if (Start) begin
            state   <= LEN_HI;
            RxReady <= 1'b1;
            Busy    <= 1'b1;
            CpuClrn <= 1'b0;
            Err     <= 1'b0;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            n[15:8] <= RxData;
            state   <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            n <= len_next;
            if (len_next == '0) begin
              state   <= DONE;
              RxReady <= 1'b0;
            end else if (len_next > DEPTH_W) begin
              state   <= ERR;
              RxReady <= 1'b0;
              Busy    <= 1'b0;
              Err     <= 1'b1;
            end else begin
              state   <= DATA;
              idx     <= '0;
              WordCnt <= '0;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            word <= {word[15:0], RxData};
            idx  <= idx + 2'd1;
            if (idx == 2'd3) begin
              state   <= WRITE;
              RxReady <= 1'b0;
              MemWe   <= 1'b1;
              MemData <= {word, RxData};
              MemAddr <= BASE_ADDR + {14'd0, WordCnt, 2'b00};
            end
          end
        end
        WRITE: begin
          MemWe   <= 1'b0;
          WordCnt <= cnt_next;
          if (cnt_next == n) begin
            state <= DONE;
          end else begin
            state   <= DATA;
            RxReady <= 1'b1;
          end
        end
        DONE: begin
          // Busy/CpuClrn settle one cycle after entry, so CpuClrn rises two edges after the last write byte.
          if (Start && !Busy) begin
            state   <= LEN_HI;
            RxReady <= 1'b1;
            Busy    <= 1'b1;
            CpuClrn <= 1'b0;
            Err     <= 1'b0;
            WordCnt <= '0;
          end else begin
            Busy    <= 1'b0;
            CpuClrn <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
